// File: rtl/cordic_quadrant_fold.sv
// Range-reduction wrapper around a CORDIC engine: folds [-pi, pi] angles into [-pi/2, pi/2],
// tracks the fold in an in-order tag FIFO and un-folds the engine's cos/sin. Optional WRAP_2PI_EN.
module cordic_quadrant_fold #(
    parameter int                    DATA_WIDTH = 18,
    parameter int                    TAG_DEPTH  = 32,
    parameter logic [DATA_WIDTH-1:0] K_INIT     = 18'h026de
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_alpha,
    output logic [DATA_WIDTH-1:0] o_eng_x,
    output logic [DATA_WIDTH-1:0] o_eng_y,
    output logic [DATA_WIDTH-1:0] o_eng_alpha,
    output logic                  o_eng_valid,
    input  logic [DATA_WIDTH-1:0] i_eng_cos,
    input  logic [DATA_WIDTH-1:0] i_eng_sin,
    input  logic                  i_eng_valid,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_cos,
    output logic [DATA_WIDTH-1:0] o_sin,
    output logic [DATA_WIDTH-1:0] o_alpha,
    output logic                  o_range_err,
    output logic                  o_underflow
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = DATA_WIDTH + 1;
    // Three guard bits keep +/-2*PI and +/-3*PI arithmetic exact on any input.
    localparam int EXT_W = DATA_WIDTH + 3;

    localparam logic [CNT_W-1:0]        DEPTH_CNT = CNT_W'(TAG_DEPTH);
    localparam logic signed [EXT_W-1:0] PI_X      = EXT_W'(51472);
    localparam logic signed [EXT_W-1:0] HALF_PI_X = EXT_W'(25736);
`ifdef WRAP_2PI_EN
    localparam logic signed [EXT_W-1:0] TWO_PI_X   = EXT_W'(102944);
    localparam logic signed [EXT_W-1:0] THREE_PI_X = EXT_W'(154416);
`endif
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] v);
        if (v == MIN_NEG) begin
            return MAX_POS;
        end
        return -v;
    endfunction

    logic                        ready;
    logic                        accept;
    logic                        tag_empty;
    logic                        pop;
    logic signed [EXT_W-1:0]     a_ext;
    logic signed [EXT_W-1:0]     a_wrap;
    logic [DATA_WIDTH-1:0]       a_fold;
    logic                        flip;
    logic                        range_bad;
    logic [TAG_W-1:0]            tag_rd;
    logic                        out_flip;
    logic [TAG_W-1:0]            tag_wr_d;

    logic [TAG_W-1:0]            tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic                        eng_valid_q, eng_valid_d;
    logic [DATA_WIDTH-1:0]       eng_alpha_q, eng_alpha_d;
    logic [DATA_WIDTH-1:0]       eng_x_q, eng_x_d;

    logic                        valid_q, valid_d;
    logic [DATA_WIDTH-1:0]       cos_q, cos_d;
    logic [DATA_WIDTH-1:0]       sin_q, sin_d;
    logic [DATA_WIDTH-1:0]       alpha_q, alpha_d;
    logic                        range_err_q, range_err_d;
    logic                        underflow_q, underflow_d;

    // Ready comes from the registered count only, so a same-cycle pop never unblocks a full FIFO.
    assign ready     = (cnt_q != DEPTH_CNT);
    assign accept    = i_valid && ready;
    assign tag_empty = (cnt_q == '0);
    assign pop       = i_eng_valid && !tag_empty;
    assign tag_rd    = tag_mem_q[rd_ptr_q];

    always_comb begin
        a_ext     = {{3{i_alpha[DATA_WIDTH-1]}}, i_alpha};
        a_wrap    = a_ext;
        range_bad = 1'b0;
`ifdef WRAP_2PI_EN
        if (a_ext > PI_X) begin
            a_wrap = a_ext - TWO_PI_X;
        end else if (a_ext < -PI_X) begin
            a_wrap = a_ext + TWO_PI_X;
        end
        range_bad = (a_ext > THREE_PI_X) || (a_ext < -THREE_PI_X);
`else
        range_bad = (a_ext > PI_X) || (a_ext < -PI_X);
`endif
        if (a_wrap > HALF_PI_X) begin
            a_fold = DATA_WIDTH'(a_wrap - PI_X);
            flip   = 1'b1;
        end else if (a_wrap < -HALF_PI_X) begin
            a_fold = DATA_WIDTH'(a_wrap + PI_X);
            flip   = 1'b1;
        end else begin
            a_fold = DATA_WIDTH'(a_wrap);
            flip   = 1'b0;
        end
    end

    always_comb begin
        eng_valid_d = accept;
        eng_alpha_d = eng_alpha_q;
        eng_x_d     = eng_x_q;
        tag_wr_d    = {i_alpha, flip};
        if (accept) begin
            eng_alpha_d = a_fold;
            eng_x_d     = K_INIT;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // An engine result with no tag outstanding is passed through unflipped with a zero angle.
    always_comb begin
        valid_d  = i_eng_valid;
        cos_d    = cos_q;
        sin_d    = sin_q;
        alpha_d  = alpha_q;
        out_flip = pop && tag_rd[0];
        if (i_eng_valid) begin
            alpha_d = pop ? tag_rd[TAG_W-1:1] : '0;
            cos_d   = out_flip ? neg_sat(i_eng_cos) : i_eng_cos;
            sin_d   = out_flip ? neg_sat(i_eng_sin) : i_eng_sin;
        end
        range_err_d = range_err_q || (accept && range_bad);
        underflow_d = underflow_q || (i_eng_valid && tag_empty);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            eng_valid_q <= 1'b0;
            eng_alpha_q <= '0;
            eng_x_q     <= '0;
            valid_q     <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
            alpha_q     <= '0;
            range_err_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            eng_valid_q <= eng_valid_d;
            eng_alpha_q <= eng_alpha_d;
            eng_x_q     <= eng_x_d;
            valid_q     <= valid_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            alpha_q     <= alpha_d;
            range_err_q <= range_err_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept && !i_rst) begin
            tag_mem_q[wr_ptr_q] <= tag_wr_d;
        end
    end

    assign o_ready     = ready;
    assign o_eng_valid = eng_valid_q;
    assign o_eng_alpha = eng_alpha_q;
    assign o_eng_x     = eng_x_q;
    assign o_eng_y     = '0;
    assign o_valid     = valid_q;
    assign o_cos       = cos_q;
    assign o_sin       = sin_q;
    assign o_alpha     = alpha_q;
    assign o_range_err = range_err_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_cordic_quadrant_fold.sv
// Scoreboard bench for cordic_quadrant_fold; the bench plays the CORDIC engine.
module tb_cordic_quadrant_fold;

    localparam int DW    = 18;
    localparam int DEPTH = 32;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_alpha;
    logic [DW-1:0] o_eng_x;
    logic [DW-1:0] o_eng_y;
    logic [DW-1:0] o_eng_alpha;
    logic          o_eng_valid;
    logic [DW-1:0] i_eng_cos;
    logic [DW-1:0] i_eng_sin;
    logic          i_eng_valid;
    logic          o_valid;
    logic [DW-1:0] o_cos;
    logic [DW-1:0] o_sin;
    logic [DW-1:0] o_alpha;
    logic          o_range_err;
    logic          o_underflow;

    cordic_quadrant_fold #(.DATA_WIDTH(DW), .TAG_DEPTH(DEPTH), .K_INIT(18'h026de)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_alpha(i_alpha), .o_eng_x(o_eng_x), .o_eng_y(o_eng_y),
        .o_eng_alpha(o_eng_alpha), .o_eng_valid(o_eng_valid),
        .i_eng_cos(i_eng_cos), .i_eng_sin(i_eng_sin), .i_eng_valid(i_eng_valid),
        .o_valid(o_valid), .o_cos(o_cos), .o_sin(o_sin), .o_alpha(o_alpha),
        .o_range_err(o_range_err), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [DW-1:0] cos;
        logic [DW-1:0] sin;
        logic [DW-1:0] alpha;
    } out_t;

    logic [DW-1:0] exp_eng_q[$];
    out_t          out_q[$];
    logic [DW:0]   tag_q[$];
    logic          exp_eng_now = 1'b0;
    logic          exp_out_now = 1'b0;
    int            n_checks = 0;
    int            n_fail   = 0;

`ifdef WRAP_2PI_EN
    localparam logic EXP_RANGE_0D000 = 1'b0;
`else
    localparam logic EXP_RANGE_0D000 = 1'b1;
`endif

    function automatic logic [DW:0] fold_m(input logic [DW-1:0] a);
        int ai;
        int w;
        ai = int'($signed(a));
        w  = ai;
`ifdef WRAP_2PI_EN
        if (ai > 51472) w = ai - 102944;
        else if (ai < -51472) w = ai + 102944;
`endif
        if (w > 25736) return {DW'(w - 51472), 1'b1};
        if (w < -25736) return {DW'(w + 51472), 1'b1};
        return {DW'(w), 1'b0};
    endfunction

    function automatic logic neg_range_m(input logic [DW-1:0] a);
        int ai;
        ai = int'($signed(a));
`ifdef WRAP_2PI_EN
        return (ai > 154416) || (ai < -154416);
`else
        return (ai > 51472) || (ai < -51472);
`endif
    endfunction

    function automatic logic [DW-1:0] neg_m(input logic [DW-1:0] v);
        int r;
        r = -int'($signed(v));
        if (r > 131071) r = 131071;
        return DW'(r);
    endfunction

    function automatic logic [DW-1:0] rand_angle();
        int v;
        v = int'($urandom_range(102944)) - 51472;
        return DW'(v);
    endfunction

    // Drive one cycle of stimulus and update the scoreboard model for that clock edge.
    task automatic drive(input logic v, input logic [DW-1:0] a, input logic ev,
                         input logic [DW-1:0] c, input logic [DW-1:0] s);
        logic        acc;
        logic [DW:0] t;
        out_t        o;
        i_valid     = v;
        i_alpha     = a;
        i_eng_valid = ev;
        i_eng_cos   = c;
        i_eng_sin   = s;
        acc = v && (tag_q.size() != DEPTH);
        if (ev) begin
            if (tag_q.size() == 0) t = '0;
            else t = tag_q.pop_front();
            o.alpha = t[DW:1];
            o.cos   = t[0] ? neg_m(c) : c;
            o.sin   = t[0] ? neg_m(s) : s;
            out_q.push_back(o);
        end
        if (acc) begin
            t = fold_m(a);
            exp_eng_q.push_back(t[DW:1]);
            tag_q.push_back({a, t[0]});
        end
        @(posedge i_clk);
        exp_eng_now = acc;
        exp_out_now = ev;
        #1;
        i_valid     = 1'b0;
        i_eng_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_eng_valid = 1'b0;
        repeat (cycles) begin
            @(posedge i_clk);
            exp_eng_now = 1'b0;
            exp_out_now = 1'b0;
        end
        tag_q.delete();
        exp_eng_q.delete();
        out_q.delete();
        #1;
        i_rst = 1'b0;
    endtask

    task automatic monitor();
        logic [DW-1:0] ea;
        out_t          eo;
        forever begin
            @(negedge i_clk);
            n_checks++;
            if (o_eng_valid !== exp_eng_now) begin
                n_fail++;
                $display("FAIL eng_valid: got %b expected %b", o_eng_valid, exp_eng_now);
            end
            if (exp_eng_now) begin
                n_checks++;
                if (exp_eng_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL eng_scoreboard: got empty queue expected entry");
                end else begin
                    ea = exp_eng_q.pop_front();
                    if ({o_eng_alpha, o_eng_x, o_eng_y} !== {ea, 18'h026de, 18'h0}) begin
                        n_fail++;
                        $display("FAIL eng_data: got alpha %h x %h y %h expected alpha %h x 026de y 00000",
                                 o_eng_alpha, o_eng_x, o_eng_y, ea);
                    end
                end
            end
            n_checks++;
            if (o_valid !== exp_out_now) begin
                n_fail++;
                $display("FAIL out_valid: got %b expected %b", o_valid, exp_out_now);
            end
            if (exp_out_now) begin
                n_checks++;
                if (out_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_scoreboard: got empty queue expected entry");
                end else begin
                    eo = out_q.pop_front();
                    if ({o_cos, o_sin, o_alpha} !== eo) begin
                        n_fail++;
                        $display("FAIL out_data: got cos %h sin %h alpha %h expected cos %h sin %h alpha %h",
                                 o_cos, o_sin, o_alpha, eo.cos, eo.sin, eo.alpha);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        n_checks++;
        if ({o_valid, o_eng_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_valids: got %b expected 00", {o_valid, o_eng_valid});
        end
        n_checks++;
        if ({o_cos, o_sin, o_alpha, o_eng_x, o_eng_y, o_eng_alpha} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h %h %h expected all zero",
                               o_cos, o_sin, o_alpha, o_eng_x, o_eng_y, o_eng_alpha);
        end
        n_checks++;
        if ({o_range_err, o_underflow} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00", {o_range_err, o_underflow});
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 18'h03424, 1'b0, '0, '0);
        n_checks++;
        if ({o_eng_alpha, o_eng_x} !== {18'h03424, 18'h026de}) begin
            n_fail++; $display("FAIL basic_eng: got alpha %h x %h expected 03424 026de", o_eng_alpha, o_eng_x);
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b1, 18'h02BA7, 18'h02E4D);
        n_checks++;
        if ({o_valid, o_cos, o_sin, o_alpha} !== {1'b1, 18'h02BA7, 18'h02E4D, 18'h03424}) begin
            n_fail++; $display("FAIL basic_out: got v %b cos %h sin %h alpha %h expected 1 02ba7 02e4d 03424",
                               o_valid, o_cos, o_sin, o_alpha);
        end
    endtask

    task automatic test_fold();
        drive(1'b1, 18'h0A000, 1'b0, '0, '0);
        n_checks++;
        if (o_eng_alpha !== 18'h3D6F0) begin
            n_fail++; $display("FAIL fold_eng_alpha: got %h expected 3d6f0", o_eng_alpha);
        end
        drive(1'b0, '0, 1'b1, 18'(13124), 18'(-9806));
        n_checks++;
        if ({o_cos, o_sin, o_alpha} !== {18'(-13124), 18'(9806), 18'h0A000}) begin
            n_fail++; $display("FAIL fold_out: got cos %h sin %h alpha %h expected %h %h 0a000",
                               o_cos, o_sin, o_alpha, 18'(-13124), 18'(9806));
        end
    endtask

    task automatic test_boundaries();
        logic [DW-1:0] bin [8];
        logic [DW-1:0] bexp [8];
        bin  = '{18'h06488, 18'h06489, 18'h39B78, 18'h39B77, 18'h0C910, 18'h336F0, 18'h00000, 18'h3FFFF};
        bexp = '{18'h06488, 18'h39B79, 18'h39B78, 18'h06487, 18'h00000, 18'h00000, 18'h00000, 18'h3FFFF};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bin[i], 1'b0, '0, '0);
            n_checks++;
            if (o_eng_alpha !== bexp[i]) begin
                n_fail++; $display("FAIL boundary_%0d: got %h expected %h", i, o_eng_alpha, bexp[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 1) drive(1'b0, '0, 1'b1, 18'h20000, 18'h01234);
            else drive(1'b0, '0, 1'b1, 18'($urandom), 18'($urandom));
            if (i == 1) begin
                n_checks++;
                if (o_cos !== 18'h1FFFF) begin
                    n_fail++; $display("FAIL saturate_cos: got %h expected 1ffff", o_cos);
                end
            end
        end
        n_checks++;
        if (o_range_err !== 1'b0) begin
            n_fail++; $display("FAIL boundary_range_err: got %b expected 0", o_range_err);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (o_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_ready_early_%0d: got %b expected 1", i, o_ready);
            end
            drive(1'b1, rand_angle(), 1'b0, '0, '0);
        end
        n_checks++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", o_ready); end
        drive(1'b1, rand_angle(), 1'b0, '0, '0);
        n_checks++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %b expected 0", o_ready); end
        drive(1'b0, '0, 1'b1, 18'($urandom), 18'($urandom));
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b expected 1", o_ready); end
        drive(1'b1, rand_angle(), 1'b1, 18'($urandom), 18'($urandom));
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_push_pop: got %b expected 1", o_ready); end
        drive(1'b1, rand_angle(), 1'b0, '0, '0);
        n_checks++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_refill: got %b expected 0", o_ready); end
        repeat (DEPTH) drive(1'b0, '0, 1'b1, 18'($urandom), 18'($urandom));
        n_checks++;
        if ({o_ready, o_underflow} !== 2'b10) begin
            n_fail++; $display("FAIL bp_drained: got ready,underflow %b expected 10", {o_ready, o_underflow});
        end
    endtask

    task automatic test_range_err();
        drive(1'b1, 18'h0D000, 1'b0, '0, '0);
        n_checks++;
        if ({o_range_err, o_eng_alpha} !== {EXP_RANGE_0D000, 18'h006F0}) begin
            n_fail++; $display("FAIL range_accept: got err %b alpha %h expected %b 006f0",
                               o_range_err, o_eng_alpha, EXP_RANGE_0D000);
        end
        n_checks++;
        if (neg_range_m(18'h0D000) !== EXP_RANGE_0D000 && o_range_err !== EXP_RANGE_0D000) begin
            n_fail++; $display("FAIL range_model: got %b expected %b", o_range_err, EXP_RANGE_0D000);
        end
        drive(1'b0, '0, 1'b1, 18'h01000, 18'h02000);
        repeat (3) drive(1'b0, '0, 1'b0, '0, '0);
        n_checks++;
        if (o_range_err !== EXP_RANGE_0D000) begin
            n_fail++; $display("FAIL range_sticky: got %b expected %b", o_range_err, EXP_RANGE_0D000);
        end
        drive(1'b0, '0, 1'b1, 18'h00123, 18'h3F000);
        n_checks++;
        if ({o_underflow, o_alpha, o_cos, o_sin} !== {1'b1, 18'h0, 18'h00123, 18'h3F000}) begin
            n_fail++; $display("FAIL underflow: got uf %b alpha %h cos %h sin %h expected 1 00000 00123 3f000",
                               o_underflow, o_alpha, o_cos, o_sin);
        end
        repeat (2) drive(1'b0, '0, 1'b0, '0, '0);
        n_checks++;
        if ({o_underflow, o_ready} !== 2'b11) begin
            n_fail++; $display("FAIL underflow_sticky: got uf,ready %b expected 11", {o_underflow, o_ready});
        end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] angles [8];
        angles = '{18'h03424, 18'h0A000, 18'h36000, 18'h06489, 18'h39B77, 18'h00100, 18'h0C910, 18'h336F0};
        repeat (6) drive(1'b1, rand_angle(), 1'b0, '0, '0);
        drive(1'b0, '0, 1'b1, 18'($urandom), 18'($urandom));
        do_reset(1);
        n_checks++;
        if ({o_ready, o_valid, o_eng_valid, o_range_err, o_underflow} !== 5'b10000) begin
            n_fail++; $display("FAIL midreset: got rdy,v,ev,re,uf %b expected 10000",
                               {o_ready, o_valid, o_eng_valid, o_range_err, o_underflow});
        end
        for (int i = 0; i < 12; i++) begin
            drive(i < 8, (i < 8) ? angles[i % 8] : '0, (i >= 3) && (i < 11),
                  18'($urandom), 18'($urandom));
        end
        repeat (2) drive(1'b0, '0, 1'b0, '0, '0);
        n_checks++;
        if ({o_ready, o_underflow, o_range_err} !== 3'b100) begin
            n_fail++; $display("FAIL stream_after_reset: got rdy,uf,re %b expected 100",
                               {o_ready, o_underflow, o_range_err});
        end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_alpha     = '0;
        i_eng_valid = 1'b0;
        i_eng_cos   = '0;
        i_eng_sin   = '0;
        test_reset();
        fork
            monitor();
        join_none
        test_basic();
        test_fold();
        test_boundaries();
        test_backpressure();
        test_range_err();
        test_reset_midstream();
        @(negedge i_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_quadrant_fold.md
Name: cordic_quadrant_fold

Overview:
- Range-reduction wrapper stage placed around the CORDIC engine.
- Takes arbitrary angles in [-pi, pi] (Q4.14, 18-bit signed) and folds them into the engine's convergence range [-pi/2, pi/2]. Drives the engine's x/y/alpha inputs with x = K (0.60729).
- Keeps a tag FIFO (original angle + fold flag) matched in order to engine results. Negates engine cos/sin for folded samples, so downstream sees cos/sin of the original angle.
- Provides upstream backpressure, since the engine itself has none.

Parameters:
- DATA_WIDTH, 18, width of angle/cos/sin words (Q4.14 when 18).
- TAG_DEPTH, 32, tag FIFO entries; must be >= engine latency + 3 for full throughput; power of two.
- K_INIT, 18'h026de, x seed driven to engine (CORDIC gain compensation).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  upstream sample valid.
- o_ready  out  1  block can accept a sample this cycle.
- i_alpha  in  DATA_WIDTH  angle, signed Q4.14 radians.
- o_eng_x  out  DATA_WIDTH  to engine in_x.
- o_eng_y  out  DATA_WIDTH  to engine in_y.
- o_eng_alpha  out  DATA_WIDTH  to engine in_alpha (folded angle).
- o_eng_valid  out  1  to engine i_valid_in.
- i_eng_cos  in  DATA_WIDTH  from engine out_costheta.
- i_eng_sin  in  DATA_WIDTH  from engine out_sintheta.
- i_eng_valid  in  1  from engine o_valid_out.
- o_valid  out  1  corrected result valid.
- o_cos  out  DATA_WIDTH  cos(original alpha).
- o_sin  out  DATA_WIDTH  sin(original alpha).
- o_alpha  out  DATA_WIDTH  original alpha, echoed.
- o_range_err  out  1  sticky: an accepted angle was outside [-PI, PI].
- o_underflow  out  1  sticky: engine result arrived with tag FIFO empty.

Behaviour:
- Constants: PI = 51472 (0x0C910), HALF_PI = 25736 (0x06488), sign-extended to DATA_WIDTH.
- Accept: a transfer happens when i_valid && o_ready.
- o_ready = (tag count != TAG_DEPTH). It depends on registered count only, not on the same-cycle pop.
- Fold (input side), computed on the accepted a:
  - a > HALF_PI: a' = a - PI, flip = 1.
  - a < -HALF_PI: a' = a + PI, flip = 1.
  - otherwise: a' = a, flip = 0.
  - Comparisons are signed. a = HALF_PI exactly is not folded.
- Input latency: 1 cycle.
  - Next cycle o_eng_valid = 1, o_eng_alpha = a', o_eng_x = K_INIT, o_eng_y = 0.
  - When no transfer, o_eng_valid = 0 and the data registers hold.
- Range check: an accepted a with a > PI or a < -PI sets o_range_err; it stays set until reset. The sample is still folded with the rule above (result is undefined but ordering is preserved).
- Tag FIFO:
  - Push {a, flip} on each transfer.
  - Pop on each i_eng_valid.
  - Count width is clog2(TAG_DEPTH)+1. Read/write pointers wrap modulo TAG_DEPTH.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Output side, registered, latency 1 cycle from i_eng_valid:
  - o_valid = 1 in that cycle.
  - o_alpha = popped a.
  - If flip: o_cos = -i_eng_cos, o_sin = -i_eng_sin, with -(min negative) saturating to max positive. Else pass through.
- Underflow: i_eng_valid with count == 0 sets o_underflow (sticky). Output is still produced with flip = 0, o_alpha = 0. Pointers and count do not change.
- Reset (any cycle, including mid-stream):
  - All outputs 0 except o_ready = 1.
  - FIFO emptied; sticky flags cleared.
  - Engine results arriving after reset count as underflow; the bench must reset the engine together with this block.

Optional Feature:
- WRAP_2PI_EN: when defined, a single pre-wrap runs before the fold and range check: a > PI becomes a - 2*PI; a < -PI becomes a + 2*PI.
  - Defined: o_range_err only flags inputs outside [-3*PI, 3*PI]. The pre-wrap adds no cycle of latency.
  - Undefined: behaviour exactly as above.

Test Plan:
- Accept alpha 0x03424 (0.815 rad) -> next cycle o_eng_alpha 0x03424, o_eng_x 0x026de, o_eng_y 0. Engine returns cos 0x0 2BA7 / sin 0x02E4D -> o_cos/o_sin identical, o_alpha 0x03424, one cycle after i_eng_valid.
- Accept alpha 0x0A000 (2.5 rad) -> o_eng_alpha 0x3D6F0 (-10512). Engine returns cos 13124, sin -9806 -> o_cos -13124, o_sin 9806, o_alpha 0x0A000.
- Boundaries: 0x06488 -> alpha unchanged, flip 0. 0x06489 -> 0x39B79 (-25735), flip 1. 0x39B78 (-HALF_PI) -> unchanged.
- Backpressure: hold i_valid with engine results stalled -> o_ready drops after exactly TAG_DEPTH accepts. A single i_eng_valid raises o_ready the next cycle. With push and pop in the same cycle, count holds.
- Alpha 0x0D000 (> PI) -> o_range_err = 1 and stays set; with WRAP_2PI_EN, no error and o_eng_alpha follows the 2*PI pre-wrap. i_eng_valid with empty FIFO -> o_underflow = 1, o_alpha 0.
- Reset asserted with 5 tags outstanding -> next cycle o_ready = 1, o_valid = 0, flags cleared. Fresh stream of 8 angles returns in order with correct signs.
